// File: rtl/eco32f_pkg.sv
// Shared definitions for the ECO32F instruction/data cache line refill engine:
// FSM state encoding, line geometry and Wishbone cycle-type constants.
package eco32f_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INV    = 2'd1,
    ST_REFILL = 2'd2,
    ST_DONE   = 2'd3
  } refill_state_e;

  localparam int         LINE_WORDS  = 8;
  localparam logic [2:0] LAST_BEAT   = 3'(LINE_WORDS - 1);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Byte address of one word inside a 32-byte line.
  function automatic logic [31:0] line_word_addr(input logic [26:0] line, input logic [2:0] beat);
    return {line, beat, 2'b00};
  endfunction

endpackage

// File: rtl/eco32f_cache_refill.sv
// Cache line refill / invalidate engine: fetches one 8-word line over Wishbone
// (registered-feedback burst or classic cycles) and writes it into the cache.
module eco32f_cache_refill
  import eco32f_pkg::*;
#(
  parameter bit OPTION_BURST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        refill_req,
  input  logic [31:0] refill_addr,
  input  logic        inv_req,
  input  logic [31:0] inv_addr,

  output logic        busy,
  output logic        refill_done,
  output logic        bus_err,

  output logic [31:0] cache_write_addr,
  output logic [31:0] cache_write_data,
  output logic        cache_write_en,
  output logic        cache_invalidate,

  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  refill_state_e state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [26:0]   line_q, line_d;
  logic          cyc_q, cyc_d;

  logic          beat_ok;
  logic          beat_err;
  logic          last_beat;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{refill_addr[4:0], inv_addr[4:0]};

  // A beat only counts while a strobe is out; err wins over a simultaneous ack.
  assign beat_err  = (state_q == ST_REFILL) && cyc_q && wbm_err_i;
  assign beat_ok   = (state_q == ST_REFILL) && cyc_q && wbm_ack_i && !wbm_err_i;
  assign last_beat = (cnt_q == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    cyc_d   = cyc_q;

    case (state_q)
      ST_IDLE: begin
        cyc_d = 1'b0;
        if (inv_req) begin
          state_d = ST_INV;
          line_d  = inv_addr[31:5];
        end else if (refill_req) begin
          state_d = ST_REFILL;
          line_d  = refill_addr[31:5];
          cnt_d   = '0;
        end
      end

      ST_INV: state_d = ST_IDLE;

      ST_REFILL: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (beat_err) begin
          cyc_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (beat_ok) begin
          cnt_d = cnt_q + 3'd1;
          if (last_beat) begin
            cyc_d   = 1'b0;
            state_d = ST_DONE;
          end else if (!OPTION_BURST) begin
            cyc_d = 1'b0;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign wbm_adr_o = line_word_addr(line_q, cnt_q);
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_bte_o = BTE_LINEAR;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hf;

  always_comb begin
    wbm_cti_o = CTI_CLASSIC;
    if (cyc_q && OPTION_BURST) begin
      wbm_cti_o = last_beat ? CTI_EOB : CTI_INCR;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign refill_done = (state_q == ST_DONE);
  assign bus_err     = beat_err;

  // The tag only turns valid with the final word, so a half-filled line never hits.
  assign cache_write_en   = (state_q == ST_INV) || beat_ok;
  assign cache_invalidate = (state_q == ST_INV) || (beat_ok && !last_beat);
  assign cache_write_addr = (state_q == ST_INV) ? line_word_addr(line_q, 3'd0) : wbm_adr_o;
  assign cache_write_data = wbm_dat_i;

endmodule

// File: tb/tb_eco32f_cache_refill.sv
// Self-checking bench for eco32f_cache_refill: a burst and a classic instance,
// each fed by a small Wishbone slave and checked against a write scoreboard.
module tb_eco32f_cache_refill;
  import eco32f_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        refillReqA, refillReqB, invReq;
  logic [31:0] refillAddr, invAddr;

  logic        busyA, doneA, busErrA, cweA, cinvA;
  logic [31:0] cwaA, cwdA, adrA, datA;
  logic        cycA, stbA, weA, ackA, errA, readyA;
  logic [2:0]  ctiA;
  logic [1:0]  bteA;
  logic [3:0]  selA;

  logic        busyB, doneB, busErrB, cweB, cinvB;
  logic [31:0] cwaB, cwdB, adrB, datB;
  logic        cycB, stbB, weB, ackB, errB, readyB;
  logic [2:0]  ctiB;
  logic [1:0]  bteB;
  logic [3:0]  selB;

  int          asserts = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  eco32f_cache_refill #(.OPTION_BURST(1'b1)) dutA (
    .clk(clk), .rst(rst),
    .refill_req(refillReqA), .refill_addr(refillAddr),
    .inv_req(invReq), .inv_addr(invAddr),
    .busy(busyA), .refill_done(doneA), .bus_err(busErrA),
    .cache_write_addr(cwaA), .cache_write_data(cwdA),
    .cache_write_en(cweA), .cache_invalidate(cinvA),
    .wbm_adr_o(adrA), .wbm_cyc_o(cycA), .wbm_stb_o(stbA), .wbm_cti_o(ctiA),
    .wbm_bte_o(bteA), .wbm_we_o(weA), .wbm_sel_o(selA),
    .wbm_dat_i(datA), .wbm_ack_i(ackA), .wbm_err_i(errA)
  );

  eco32f_cache_refill #(.OPTION_BURST(1'b0)) dutB (
    .clk(clk), .rst(rst),
    .refill_req(refillReqB), .refill_addr(refillAddr),
    .inv_req(1'b0), .inv_addr(32'h0),
    .busy(busyB), .refill_done(doneB), .bus_err(busErrB),
    .cache_write_addr(cwaB), .cache_write_data(cwdB),
    .cache_write_en(cweB), .cache_invalidate(cinvB),
    .wbm_adr_o(adrB), .wbm_cyc_o(cycB), .wbm_stb_o(stbB), .wbm_cti_o(ctiB),
    .wbm_bte_o(bteB), .wbm_we_o(weB), .wbm_sel_o(selB),
    .wbm_dat_i(datB), .wbm_ack_i(ackB), .wbm_err_i(errB)
  );

  // Memory contents seen by both slaves: a fixed scramble of the word address.
  function automatic logic [31:0] dataFor(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // Slave: answers every (waitStates+1)-th strobed cycle, errors on beat errBeat.
  int   waitStates = 0;
  int   errBeat = -1;
  logic slaveClr;
  int   waitA, beatA, waitB, beatB;

  assign readyA = cycA && stbA && (waitA == waitStates);
  assign ackA   = readyA && (beatA != errBeat);
  assign errA   = readyA && (beatA == errBeat);
  assign datA   = ackA ? dataFor(adrA) : 32'hDEAD_BEEF;

  assign readyB = cycB && stbB && (waitB == waitStates);
  assign ackB   = readyB && (beatB != errBeat);
  assign errB   = readyB && (beatB == errBeat);
  assign datB   = ackB ? dataFor(adrB) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (slaveClr) begin
      waitA <= 0; beatA <= 0; waitB <= 0; beatB <= 0;
    end else begin
      if (readyA) begin waitA <= 0; beatA <= beatA + 1; end
      else if (cycA && stbA) waitA <= waitA + 1;
      if (readyB) begin waitB <= 0; beatB <= beatB + 1; end
      else if (cycB && stbB) waitB <= waitB + 1;
    end
  end

  // Scoreboard of cache writes each instance owes, plus the line it is filling.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        inv;
    logic        chkData;
  } wr_t;

  wr_t         expA[$];
  wr_t         expB[$];
  logic [26:0] lineA = '0;
  logic [26:0] lineB = '0;

  typedef struct {
    int          edges;
    int          doneCycles;
    int          writes;
    int          errPulses;
    int          invCount;
    int          lastWrEdge;
    logic [31:0] firstAddr;
    logic [31:0] lastAddr;
    logic [2:0]  lastCti;
  } fill_res_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    asserts++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
    end
  endtask

  task automatic expectFill(input bit isB, input logic [31:0] addr, input int beats);
    wr_t e;
    for (int i = 0; i < beats; i++) begin
      e.addr    = {addr[31:5], 5'b0} + 32'(4 * i);
      e.data    = dataFor(e.addr);
      e.inv     = (i < LINE_WORDS - 1);
      e.chkData = 1'b1;
      if (isB) expB.push_back(e); else expA.push_back(e);
    end
    if (isB) lineB = addr[31:5]; else lineA = addr[31:5];
  endtask

  task automatic expectInv(input logic [31:0] addr);
    wr_t e;
    e.addr    = {addr[31:5], 5'b0};
    e.data    = '0;
    e.inv     = 1'b1;
    e.chkData = 1'b0;
    expA.push_back(e);
  endtask

  task automatic popCheck(input bit isB, input logic [31:0] a, input logic [31:0] d, input logic inv);
    wr_t   e;
    string tag;
    tag = isB ? "B" : "A";
    if ((isB && expB.size() == 0) || (!isB && expA.size() == 0)) begin
      asserts++;
      failures++;
      $display("[TB] FAIL %s unexpected write: actual addr %h, required no write", tag, a);
    end else begin
      if (isB) e = expB.pop_front(); else e = expA.pop_front();
      checkOutput({tag, " write addr"}, a, e.addr);
      if (e.chkData) checkOutput({tag, " write data"}, d, e.data);
      checkOutput({tag, " write invalidate"}, 32'(inv), 32'(e.inv));
    end
  endtask

  // Per-cycle compare process, away from the rising edge.
  logic prevContA = 1'b0, prevEndA = 1'b0, prevAckB = 1'b0, prevErrB = 1'b0;

  always @(negedge clk) begin
    if (cweA) popCheck(1'b0, cwaA, cwdA, cinvA);
    if (cweB) popCheck(1'b1, cwaB, cwdB, cinvB);

    checkOutput("A bus_err", 32'(busErrA), 32'(errA));
    checkOutput("B bus_err", 32'(busErrB), 32'(errB));
    if (errA) checkOutput("A write on err", 32'(cweA), 32'h0);
    if (errB) checkOutput("B write on err", 32'(cweB), 32'h0);
    if (doneA) checkOutput("A busy in done", 32'(busyA), 32'h1);

    if (stbA) begin
      checkOutput("A adr line", 32'(adrA[31:5]), 32'(lineA));
      checkOutput("A cti", 32'(ctiA), 32'((adrA[4:2] == 3'd7) ? CTI_EOB : CTI_INCR));
      checkOutput("A fixed bus", {24'h0, weA, selA, bteA, cycA}, {24'h0, 1'b0, 4'hf, 2'b00, 1'b1});
    end
    if (stbB) begin
      checkOutput("B adr line", 32'(adrB[31:5]), 32'(lineB));
      checkOutput("B cti", 32'(ctiB), 32'(CTI_CLASSIC));
      checkOutput("B fixed bus", {24'h0, weB, selB, bteB, cycB}, {24'h0, 1'b0, 4'hf, 2'b00, 1'b1});
    end

    if (prevContA) checkOutput("A burst continues", 32'(cycA && stbA), 32'h1);
    if (prevEndA)  checkOutput("A cycle ends", 32'(cycA || stbA), 32'h0);
    if (prevAckB)  checkOutput("B gap after beat", 32'(cycB || stbB), 32'h0);
    if (prevErrB)  checkOutput("B cycle ends on err", 32'(cycB || stbB), 32'h0);

    prevContA = !rst && ackA && (adrA[4:2] != 3'd7);
    prevEndA  = !rst && ((ackA && adrA[4:2] == 3'd7) || errA);
    prevAckB  = !rst && ackB;
    prevErrB  = !rst && errB;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic slaveSetup(input int ws, input int eb);
    waitStates = ws;
    errBeat    = eb;
    slaveClr   = 1'b1;
    tick(1);
    slaveClr   = 1'b0;
  endtask

  // Raise refill_req and hold it until busy is seen; returns just after the accepting edge.
  task automatic applyStimulus(input bit isB, input logic [31:0] addr);
    bit seen;
    seen = 1'b0;
    refillAddr = addr;
    if (isB) refillReqB = 1'b1; else refillReqA = 1'b1;
    for (int n = 0; n < 5 && !seen; n++) begin
      tick(1);
      seen = isB ? busyB : busyA;
    end
    refillReqA = 1'b0;
    refillReqB = 1'b0;
    checkOutput(isB ? "B request accepted" : "A request accepted", 32'(seen), 32'h1);
  endtask

  // Follows one fill until the engine is idle again, recording what it saw.
  task automatic waitDone(input bit isB, input int maxCycles, input bit holdOthers, output fill_res_t r);
    logic b, d, e, we, inv;
    logic [31:0] wa;
    logic [2:0]  cti;
    r.edges = 0; r.doneCycles = 0; r.writes = 0; r.errPulses = 0; r.invCount = 0;
    r.lastWrEdge = 0; r.firstAddr = '0; r.lastAddr = '0; r.lastCti = '0;
    if (holdOthers) begin
      refillReqA = 1'b1;
      invReq     = 1'b1;
      invAddr    = 32'h0000_ABC4;
      refillAddr = 32'hFFFF_0000;
    end
    for (int n = 1; n <= maxCycles; n++) begin
      tick(1);
      if (isB) begin b = busyB; d = doneB; e = busErrB; we = cweB; inv = cinvB; wa = cwaB; cti = ctiB; end
      else     begin b = busyA; d = doneA; e = busErrA; we = cweA; inv = cinvA; wa = cwaA; cti = ctiA; end
      if (we) begin
        if (r.writes == 0) r.firstAddr = wa;
        r.lastAddr   = wa;
        r.lastCti    = cti;
        r.lastWrEdge = n;
        r.writes++;
        if (inv) r.invCount++;
      end
      if (e) r.errPulses++;
      if (d) begin
        if (r.doneCycles == 0) r.edges = n;
        r.doneCycles++;
      end
      if (!b) begin
        if (r.doneCycles == 0) r.edges = n;
        break;
      end
    end
    refillReqA = 1'b0;
    invReq     = 1'b0;
    if (isB) checkOutput("B idle after fill", 32'(busyB), 32'h0);
    else     checkOutput("A idle after fill", 32'(busyA), 32'h0);
  endtask

  fill_res_t res;

  initial begin
    rst = 1'b1; slaveClr = 1'b1;
    refillReqA = 1'b0; refillReqB = 1'b0; invReq = 1'b0;
    refillAddr = '0; invAddr = '0;
    tick(2);
    checkOutput("A reset outputs", {20'h0, cycA, stbA, cweA, busyA, doneA, busErrA, cinvA, ctiA, 2'b00}, 32'h0);
    checkOutput("B reset outputs", {20'h0, cycB, stbB, cweB, busyB, doneB, busErrB, cinvB, ctiB, 2'b00}, 32'h0);
    rst = 1'b0;
    slaveClr = 1'b0;

    // Zero-wait burst fill of 0x1234: entry cycle, 8 beats, done in the tenth cycle.
    $display("[TB] burst fill, zero wait");
    slaveSetup(0, -1);
    expectFill(1'b0, 32'h0000_1234, 8);
    applyStimulus(1'b0, 32'h0000_1234);
    waitDone(1'b0, 40, 1'b0, res);
    checkOutput("burst writes", 32'(res.writes), 32'd8);
    checkOutput("burst first addr", res.firstAddr, 32'h0000_1220);
    checkOutput("burst last addr", res.lastAddr, 32'h0000_123C);
    checkOutput("burst last cti", 32'(res.lastCti), 32'h7);
    checkOutput("burst invalidate count", 32'(res.invCount), 32'd7);
    checkOutput("burst done edge", 32'(res.edges), 32'd9);
    checkOutput("burst done width", 32'(res.doneCycles), 32'd1);

    // Ack every third cycle, with refill/inv requests held throughout (must be ignored).
    $display("[TB] burst fill, wait states");
    slaveSetup(2, -1);
    expectFill(1'b0, 32'h0000_5678, 8);
    applyStimulus(1'b0, 32'h0000_5678);
    waitDone(1'b0, 80, 1'b1, res);
    checkOutput("wait writes", 32'(res.writes), 32'd8);
    checkOutput("wait first addr", res.firstAddr, 32'h0000_5660);
    checkOutput("wait done edge", 32'(res.edges), 32'd25);
    checkOutput("wait done after last ack", 32'(res.edges), 32'(res.lastWrEdge + 1));
    tick(2);
    checkOutput("held requests ignored", 32'(busyA), 32'h0);

    // Bus error on beat 4, then a clean refill of the same line.
    $display("[TB] bus error mid-burst");
    slaveSetup(0, 4);
    expectFill(1'b0, 32'h0000_3010, 4);
    applyStimulus(1'b0, 32'h0000_3010);
    waitDone(1'b0, 40, 1'b0, res);
    checkOutput("err writes", 32'(res.writes), 32'd4);
    checkOutput("err pulses", 32'(res.errPulses), 32'd1);
    checkOutput("err no done", 32'(res.doneCycles), 32'd0);
    checkOutput("err idle edge", 32'(res.edges), 32'd6);
    checkOutput("err cyc dropped", 32'(cycA), 32'h0);
    slaveSetup(0, -1);
    expectFill(1'b0, 32'h0000_3010, 8);
    applyStimulus(1'b0, 32'h0000_3010);
    waitDone(1'b0, 40, 1'b0, res);
    checkOutput("retry writes", 32'(res.writes), 32'd8);
    checkOutput("retry done width", 32'(res.doneCycles), 32'd1);

    // Invalidate wins over a simultaneous refill; the refill follows because it stays held.
    $display("[TB] invalidate beats refill");
    invAddr = 32'h0000_2040;
    refillAddr = 32'h0000_4004;
    expectInv(32'h0000_2040);
    expectFill(1'b0, 32'h0000_4004, 8);
    invReq = 1'b1;
    refillReqA = 1'b1;
    tick(1);
    checkOutput("inv write en", 32'(cweA), 32'h1);
    checkOutput("inv invalidate", 32'(cinvA), 32'h1);
    checkOutput("inv addr", cwaA, 32'h0000_2040);
    invReq = 1'b0;
    tick(1);
    checkOutput("inv single cycle", {30'h0, busyA, cweA}, 32'h0);
    tick(1);
    checkOutput("held refill accepted", 32'(busyA), 32'h1);
    refillReqA = 1'b0;
    waitDone(1'b0, 40, 1'b0, res);
    checkOutput("after inv done edge", 32'(res.edges), 32'd9);
    checkOutput("after inv writes", 32'(res.writes), 32'd8);

    // Both requests dropped after the invalidate: no refill may follow.
    invAddr = 32'h0000_60A8;
    refillAddr = 32'h0000_8000;
    expectInv(32'h0000_60A8);
    invReq = 1'b1;
    refillReqA = 1'b1;
    tick(1);
    checkOutput("inv masked addr", cwaA, 32'h0000_60A0);
    invReq = 1'b0;
    refillReqA = 1'b0;
    tick(3);
    checkOutput("no refill after inv", 32'(busyA), 32'h0);

    // Reset asserted during beat 3.
    $display("[TB] reset mid-burst");
    slaveSetup(0, -1);
    expectFill(1'b0, 32'h0000_7008, 4);
    applyStimulus(1'b0, 32'h0000_7008);
    tick(4);
    checkOutput("beat3 addr", cwaA, 32'h0000_700C);
    rst = 1'b1;
    tick(1);
    checkOutput("A outputs after reset", {20'h0, cycA, stbA, cweA, busyA, doneA, busErrA, cinvA, ctiA, 2'b00}, 32'h0);
    rst = 1'b0;
    slaveSetup(0, -1);
    expectFill(1'b0, 32'h0000_7008, 8);
    applyStimulus(1'b0, 32'h0000_7008);
    waitDone(1'b0, 40, 1'b0, res);
    checkOutput("post-reset first addr", res.firstAddr, 32'h0000_7000);
    checkOutput("post-reset writes", 32'(res.writes), 32'd8);

    // Classic single-beat build: same writes, a strobe gap between beats.
    $display("[TB] classic fill");
    slaveSetup(0, -1);
    expectFill(1'b1, 32'h0000_9ABC, 8);
    applyStimulus(1'b1, 32'h0000_9ABC);
    waitDone(1'b1, 60, 1'b0, res);
    checkOutput("classic writes", 32'(res.writes), 32'd8);
    checkOutput("classic first addr", res.firstAddr, 32'h0000_9AA0);
    checkOutput("classic last addr", res.lastAddr, 32'h0000_9ABC);
    checkOutput("classic last cti", 32'(res.lastCti), 32'h0);
    checkOutput("classic invalidate count", 32'(res.invCount), 32'd7);
    checkOutput("classic done edge", 32'(res.edges), 32'd16);

    tick(2);
    checkOutput("A pending writes", 32'(expA.size()), 32'd0);
    checkOutput("B pending writes", 32'(expB.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
